// File: rtl/ap_seq_if.sv
// Stream and associative-processor bus bundle for ap_seq.
// master = sequencer side, slave = environment (stream source/sink and AP array).
interface ap_seq_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_W    = 9
);
  logic                 s_valid;
  logic                 s_ready;
  logic [WORD_SIZE-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [WORD_SIZE-1:0] m_data;
  logic                 m_last;
  logic [ADDR_W-1:0]    ap_addr;
  logic [WORD_SIZE-1:0] ap_data;
  logic                 ap_write_en;
  logic                 ap_read_en;
  logic                 ap_mode;
  logic                 ap_rst;
  logic                 ap_sel_internal_col;
  logic [1:0]           ap_sel_col;
  logic [2:0]           ap_cmd;
  logic [WORD_SIZE-1:0] ap_data_out;
  logic                 ap_state_irq;

  modport master (
    input  s_valid, s_data, m_ready, ap_data_out, ap_state_irq,
    output s_ready, m_valid, m_data, m_last, ap_addr, ap_data, ap_write_en,
           ap_read_en, ap_mode, ap_rst, ap_sel_internal_col, ap_sel_col, ap_cmd
  );

  modport slave (
    output s_valid, s_data, m_ready, ap_data_out, ap_state_irq,
    input  s_ready, m_valid, m_data, m_last, ap_addr, ap_data, ap_write_en,
           ap_read_en, ap_mode, ap_rst, ap_sel_internal_col, ap_sel_col, ap_cmd
  );
endinterface

// File: rtl/ap_seq.sv
// Job sequencer for an associative-processor column: clear, load A/B, compute, read back.
// Optional compute watchdog enabled by defining AP_SEQ_TIMEOUT_EN.
module ap_seq #(
  parameter int WORD_SIZE      = 8,
  parameter int CELL_QUANT     = 512,
  parameter int ADDR_W         = $clog2(CELL_QUANT),
  parameter int READ_LAT       = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        CLK100MHZ,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  cmd_in,
  input  logic        bank_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  ap_seq_if.master    bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_LOAD_A  = 3'd2;
  localparam logic [2:0] S_LOAD_B  = 3'd3;
  localparam logic [2:0] S_COMPUTE = 3'd4;
  localparam logic [2:0] S_READ    = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELL_QUANT - 1);

  logic [2:0]                 state_q, state_d;
  logic [2:0]                 cmd_q, cmd_d;
  logic                       bank_q, bank_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [ADDR_W-1:0]          cell_q, cell_d;
  logic                       rd_all_q, rd_all_d;
  logic                       rd_last_q, rd_last_d;
  logic [2:0]                 inflight_q, inflight_d;
  logic [READ_LAT-1:0]        vpipe_q, vpipe_d;
  logic [READ_LAT-1:0]        lpipe_q, lpipe_d;
  logic [3:0][WORD_SIZE-1:0]  fifo_data_q, fifo_data_d;
  logic [3:0]                 fifo_last_q, fifo_last_d;
  logic [1:0]                 wr_ptr_q, wr_ptr_d;
  logic [1:0]                 rd_ptr_q, rd_ptr_d;
  logic [2:0]                 fifo_cnt_q, fifo_cnt_d;
  logic [ADDR_W-1:0]          ap_addr_q, ap_addr_d;
  logic [WORD_SIZE-1:0]       ap_data_q, ap_data_d;
  logic                       ap_we_q, ap_we_d;
  logic                       ap_re_q, ap_re_d;
  logic                       ap_mode_q, ap_mode_d;
  logic                       ap_rst_q, ap_rst_d;
  logic                       ap_sic_q, ap_sic_d;
  logic [1:0]                 ap_sel_col_q, ap_sel_col_d;
  logic [2:0]                 ap_cmd_q, ap_cmd_d;
`ifdef AP_SEQ_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0]                to_cnt_q, to_cnt_d;
  logic                       error_q, error_d;
`endif

  logic              beat;
  logic              push;
  logic              pop;
  logic              head_last;
  logic              issue;
  logic [2:0]        free_slots;
  logic [ADDR_W-1:0] cell_next;

  assign beat       = bus.s_valid & bus.s_ready;
  assign push       = vpipe_q[READ_LAT-1];
  assign pop        = bus.m_valid & bus.m_ready;
  assign head_last  = fifo_last_q[rd_ptr_q];
  assign free_slots = 3'd4 - fifo_cnt_q;
  assign cell_next  = (cell_q == LAST_CELL) ? '0 : cell_q + ADDR_W'(1'b1);

  // Job FSM and next values of the registered AP strobes.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    bank_d       = bank_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cell_d       = cell_q;
    rd_all_d     = rd_all_q;
    rd_last_d    = 1'b0;
    issue        = 1'b0;
    ap_addr_d    = '0;
    ap_data_d    = '0;
    ap_we_d      = 1'b0;
    ap_re_d      = 1'b0;
    ap_mode_d    = 1'b0;
    ap_rst_d     = 1'b0;
    ap_sel_col_d = 2'd0;
    ap_cmd_d     = 3'd0;
`ifdef AP_SEQ_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    error_d      = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d    = cmd_in;
          bank_d   = bank_in;
          busy_d   = 1'b1;
          ap_rst_d = 1'b1;
          cell_d   = '0;
          rd_all_d = 1'b0;
          state_d  = S_CLEAR;
`ifdef AP_SEQ_TIMEOUT_EN
          error_d  = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        cell_d  = '0;
        state_d = S_LOAD_A;
      end
      S_LOAD_A, S_LOAD_B: begin
        if (beat) begin
          ap_we_d      = 1'b1;
          ap_data_d    = bus.s_data;
          ap_addr_d    = cell_q;
          ap_sel_col_d = (state_q == S_LOAD_B) ? 2'd1 : 2'd0;
          cell_d       = cell_next;
          if (cell_q != LAST_CELL) begin
            state_d = state_q;
          end else if (state_q == S_LOAD_A) begin
            state_d = S_LOAD_B;
          end else begin
            state_d   = S_COMPUTE;
            ap_mode_d = 1'b1;
            ap_cmd_d  = cmd_q;
`ifdef AP_SEQ_TIMEOUT_EN
            to_cnt_d  = '0;
`endif
          end
        end else begin
          ap_we_d = 1'b0;
        end
      end
      S_COMPUTE: begin
        if (bus.ap_state_irq) begin
          state_d  = S_READ;
          cell_d   = '0;
          rd_all_d = 1'b0;
        end
`ifdef AP_SEQ_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end
`endif
        else begin
          ap_mode_d = 1'b1;
          ap_cmd_d  = cmd_q;
`ifdef AP_SEQ_TIMEOUT_EN
          to_cnt_d  = to_cnt_q + 32'd1;
`endif
        end
      end
      S_READ: begin
        // Reads in flight already own FIFO slots, so a new read needs a slot beyond them.
        if (!rd_all_q && (free_slots > inflight_q)) begin
          issue        = 1'b1;
          ap_re_d      = 1'b1;
          ap_addr_d    = cell_q;
          ap_sel_col_d = 2'd2;
          cell_d       = cell_next;
          rd_last_d    = (cell_q == LAST_CELL);
          rd_all_d     = (cell_q == LAST_CELL);
        end else begin
          issue = 1'b0;
        end
        if (pop && head_last) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_READ;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    ap_sic_d = busy_d ? bank_d : 1'b0;
  end

  // Read-latency tracking, output FIFO and in-flight accounting.
  always_comb begin
    vpipe_d     = (vpipe_q << 1) | READ_LAT'(ap_re_q);
    lpipe_d     = (lpipe_q << 1) | READ_LAT'(rd_last_q);
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = bus.ap_data_out;
      fifo_last_d[wr_ptr_q] = lpipe_q[READ_LAT-1];
      wr_ptr_d              = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    fifo_cnt_d = fifo_cnt_q + {2'b00, push} - {2'b00, pop};
    inflight_d = inflight_q + {2'b00, issue} - {2'b00, push};
  end

  // State registers; everything clears asynchronously on rst_n.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= 3'd0;
      bank_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cell_q       <= '0;
      rd_all_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      inflight_q   <= 3'd0;
      vpipe_q      <= '0;
      lpipe_q      <= '0;
      fifo_data_q  <= '0;
      fifo_last_q  <= 4'd0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      fifo_cnt_q   <= 3'd0;
      ap_addr_q    <= '0;
      ap_data_q    <= '0;
      ap_we_q      <= 1'b0;
      ap_re_q      <= 1'b0;
      ap_mode_q    <= 1'b0;
      ap_rst_q     <= 1'b0;
      ap_sic_q     <= 1'b0;
      ap_sel_col_q <= 2'd0;
      ap_cmd_q     <= 3'd0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      bank_q       <= bank_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cell_q       <= cell_d;
      rd_all_q     <= rd_all_d;
      rd_last_q    <= rd_last_d;
      inflight_q   <= inflight_d;
      vpipe_q      <= vpipe_d;
      lpipe_q      <= lpipe_d;
      fifo_data_q  <= fifo_data_d;
      fifo_last_q  <= fifo_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      ap_addr_q    <= ap_addr_d;
      ap_data_q    <= ap_data_d;
      ap_we_q      <= ap_we_d;
      ap_re_q      <= ap_re_d;
      ap_mode_q    <= ap_mode_d;
      ap_rst_q     <= ap_rst_d;
      ap_sic_q     <= ap_sic_d;
      ap_sel_col_q <= ap_sel_col_d;
      ap_cmd_q     <= ap_cmd_d;
    end
  end

`ifdef AP_SEQ_TIMEOUT_EN
  // Compute watchdog counter and sticky error flag.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= 32'd0;
      error_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      error_q  <= error_d;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign busy                    = busy_q;
  assign done                    = done_q;
  assign bus.s_ready             = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign bus.m_valid             = (fifo_cnt_q != 3'd0);
  assign bus.m_data              = fifo_data_q[rd_ptr_q];
  assign bus.m_last              = bus.m_valid & head_last;
  assign bus.ap_addr             = ap_addr_q;
  assign bus.ap_data             = ap_data_q;
  assign bus.ap_write_en         = ap_we_q;
  assign bus.ap_read_en          = ap_re_q;
  assign bus.ap_mode             = ap_mode_q;
  assign bus.ap_rst              = ap_rst_q;
  assign bus.ap_sel_internal_col = ap_sic_q;
  assign bus.ap_sel_col          = ap_sel_col_q;
  assign bus.ap_cmd              = ap_cmd_q;

endmodule

// File: tb/tb_ap_seq.sv
// Directed bench for ap_seq with a small AP array model (C = A | B, irq 10 cycles after ap_mode).
module tb_ap_seq;
  localparam int WS = 8;
  localparam int CQ = 4;
  localparam int AW = 2;
  localparam int RL = 1;
  localparam int TO = 32;

  typedef logic [3:0][7:0] col_t;
  typedef struct packed {
    col_t       a;
    col_t       b;
    logic [2:0] cmd;
    logic       bp;
    logic       gaps;
    col_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] cmd_in;
  logic       bank_in;
  logic       busy, done, error;
  logic       bp_mode = 1'b0;
  logic       irq_en = 1'b1;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  ap_seq_if #(.WORD_SIZE(WS), .ADDR_W(AW)) bus ();

  ap_seq #(.WORD_SIZE(WS), .CELL_QUANT(CQ), .ADDR_W(AW), .READ_LAT(RL), .TIMEOUT_CYCLES(TO)) dut (
    .CLK100MHZ(clk), .rst_n(rst_n), .start(start), .cmd_in(cmd_in), .bank_in(bank_in),
    .busy(busy), .done(done), .error(error), .bus(bus)
  );

  // AP array model
  logic [7:0] mem_a [4];
  logic [7:0] mem_b [4];
  int         mode_cnt;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      bus.ap_data_out  <= 8'd0;
      bus.ap_state_irq <= 1'b0;
      mode_cnt         <= 0;
    end else begin
      if (bus.ap_rst) begin
        for (int i = 0; i < 4; i++) begin
          mem_a[i] <= 8'd0;
          mem_b[i] <= 8'd0;
        end
      end else if (bus.ap_write_en && bus.ap_sel_col == 2'd0) begin
        mem_a[bus.ap_addr] <= bus.ap_data;
      end else if (bus.ap_write_en && bus.ap_sel_col == 2'd1) begin
        mem_b[bus.ap_addr] <= bus.ap_data;
      end
      if (bus.ap_read_en && bus.ap_sel_col == 2'd2)
        bus.ap_data_out <= mem_a[bus.ap_addr] | mem_b[bus.ap_addr];
      if (!bus.ap_mode) begin
        mode_cnt         <= 0;
        bus.ap_state_irq <= 1'b0;
      end else begin
        mode_cnt         <= mode_cnt + 1;
        bus.ap_state_irq <= irq_en && (mode_cnt >= 9);
      end
    end
  end

  // Result sink backpressure: always ready, or the 1,0,0 repeating pattern
  int ph = 0;
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      bus.m_ready = (ph == 0);
      ph = (ph + 1) % 3;
    end else begin
      bus.m_ready = 1'b1;
    end
  end

  // Monitor
  logic [7:0]  out_data [$];
  logic        out_last [$];
  logic [11:0] wr_log [$];
  int done_cnt = 0, rst_cnt = 0, rd_cnt = 0, mvalid_cnt = 0;
  int done_cyc = 0, mode_cyc = 0, max_occ = 0;
  logic mode_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_valid && bus.m_ready) begin
        out_data.push_back(bus.m_data);
        out_last.push_back(bus.m_last);
      end
      if (bus.m_valid) mvalid_cnt <= mvalid_cnt + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (bus.ap_write_en) wr_log.push_back({bus.ap_sel_col, bus.ap_addr, bus.ap_data});
      if (bus.ap_rst) rst_cnt <= rst_cnt + 1;
      if (bus.ap_read_en) rd_cnt <= rd_cnt + 1;
      if (bus.ap_mode && !mode_prev) mode_cyc <= cyc;
      mode_prev <= bus.ap_mode;
      if (int'(dut.fifo_cnt_q) > max_occ) max_occ <= int'(dut.fifo_cnt_q);
    end
  end

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  function automatic col_t mk(logic [7:0] e0, logic [7:0] e1, logic [7:0] e2, logic [7:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [63:0] all_outputs();
    return {30'd0, busy, done, error, bus.s_ready, bus.m_valid, bus.m_last, bus.m_data,
            bus.ap_addr, bus.ap_data, bus.ap_write_en, bus.ap_read_en, bus.ap_mode,
            bus.ap_rst, bus.ap_sel_internal_col, bus.ap_sel_col, bus.ap_cmd};
  endfunction

  task automatic start_job(input logic [2:0] cmd);
    @(posedge clk); #1;
    start = 1'b1; cmd_in = cmd; bank_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cmd_in = 3'd0; bank_in = 1'b0;
  endtask

  task automatic send_col(input col_t c, input logic gaps, input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = c[i];
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
        @(negedge clk);
        acc = bus.s_ready;
        @(posedge clk); #1;
      end
      if (!acc) check("s_ready_timeout", 64'(acc), 64'd1);
      bus.s_valid = 1'b0;
      bus.s_data  = 8'd0;
      if (gaps) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input int base);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (done_cnt != base) break;
    end
    check("done_seen", 64'(done_cnt != base), 64'd1);
    repeat (5) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int ob = out_data.size();
    int wb = wr_log.size();
    int db = done_cnt;
    int rb = rst_cnt;
    logic [11:0] ew;
    bp_mode = v.bp;
    start_job(v.cmd);
    send_col(v.a, v.gaps, 4);
    send_col(v.b, v.gaps, 4);
    wait_done(db);
    check({tag, "_beats"}, 64'(out_data.size() - ob), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (ob + i < out_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), 64'(out_data[ob+i]), 64'(v.exp[i]));
        check($sformatf("%s_last%0d", tag, i), 64'(out_last[ob+i]), 64'(i == 3));
      end
    end
    check({tag, "_writes"}, 64'(wr_log.size() - wb), 64'd8);
    for (int i = 0; i < 8; i++) begin
      ew = {(i < 4) ? 2'd0 : 2'd1, 2'(i % 4), (i < 4) ? v.a[i%4] : v.b[i%4]};
      if (wb + i < wr_log.size())
        check($sformatf("%s_wr%0d", tag, i), 64'(wr_log[wb+i]), 64'(ew));
    end
    check({tag, "_done_cnt"}, 64'(done_cnt - db), 64'd1);
    check({tag, "_clear_cnt"}, 64'(rst_cnt - rb), 64'd1);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_max_occ"}, 64'(max_occ <= 4), 64'd1);
    bp_mode = 1'b0;
  endtask

  vec_t vecs [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int db, rb, ob, mb, rdb;
    vecs[0] = '{a: mk(8'd1, 8'd2, 8'd4, 8'd8), b: mk(8'd16, 8'd32, 8'd64, 8'd128), cmd: 3'd0,
                bp: 1'b0, gaps: 1'b0, exp: mk(8'd17, 8'd34, 8'd68, 8'd136)};
    vecs[1] = '{a: mk(8'd1, 8'd2, 8'd4, 8'd8), b: mk(8'd16, 8'd32, 8'd64, 8'd128), cmd: 3'd0,
                bp: 1'b1, gaps: 1'b0, exp: mk(8'd17, 8'd34, 8'd68, 8'd136)};
    vecs[2] = '{a: mk(8'd1, 8'd2, 8'd4, 8'd8), b: mk(8'd16, 8'd32, 8'd64, 8'd128), cmd: 3'd0,
                bp: 1'b0, gaps: 1'b1, exp: mk(8'd17, 8'd34, 8'd68, 8'd136)};
    vecs[3] = '{a: mk(8'hF0, 8'h0F, 8'hAA, 8'h00), b: mk(8'h0F, 8'h00, 8'h55, 8'h00), cmd: 3'd3,
                bp: 1'b1, gaps: 1'b1, exp: mk(8'hFF, 8'h0F, 8'hFF, 8'h00)};

    rst_n = 1'b0; start = 1'b0; cmd_in = 3'd0; bank_in = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 64'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Asynchronous reset in the middle of LOAD_B, then a full job.
    start_job(3'd0);
    send_col(vecs[0].a, 1'b0, 4);
    send_col(vecs[0].b, 1'b0, 2);
    bus.s_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("midjob_reset_outputs", all_outputs(), 64'd0);
    bus.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midjob_reset_hold", all_outputs(), 64'd0);
    rst_n = 1'b1;
    run_vec(vecs[0], "after_rst");

    // start pulsed during READ must be ignored.
    db = done_cnt; rb = rst_cnt; ob = out_data.size(); rdb = rd_cnt;
    bp_mode = 1'b1;
    start_job(3'd2);
    send_col(vecs[0].a, 1'b0, 4);
    send_col(vecs[0].b, 1'b0, 4);
    for (int k = 0; k < 100 && rd_cnt == rdb; k++) @(negedge clk);
    check("read_reached", 64'(rd_cnt != rdb), 64'd1);
    @(posedge clk); #1;
    start = 1'b1; cmd_in = 3'd5;
    @(posedge clk); #1;
    start = 1'b0; cmd_in = 3'd0;
    wait_done(db);
    repeat (20) @(negedge clk);
    check("rdstart_done_cnt", 64'(done_cnt - db), 64'd1);
    check("rdstart_clear_cnt", 64'(rst_cnt - rb), 64'd1);
    check("rdstart_busy", 64'(busy), 64'd0);
    check("rdstart_beats", 64'(out_data.size() - ob), 64'd4);
    if (out_data.size() == ob + 4)
      check("rdstart_last_data", 64'(out_data[ob+3]), 64'd136);
    bp_mode = 1'b0;

`ifdef AP_SEQ_TIMEOUT_EN
    // Watchdog: irq never raised.
    db = done_cnt; mb = mvalid_cnt;
    irq_en = 1'b0;
    start_job(3'd1);
    send_col(vecs[0].a, 1'b0, 4);
    send_col(vecs[0].b, 1'b0, 4);
    wait_done(db);
    check("to_delay", 64'(done_cyc - mode_cyc), 64'd32);
    check("to_error", 64'(error), 64'd1);
    check("to_mode", 64'(bus.ap_mode), 64'd0);
    check("to_no_mvalid", 64'(mvalid_cnt - mb), 64'd0);
    check("to_done_cnt", 64'(done_cnt - db), 64'd1);
    irq_en = 1'b1;
    run_vec(vecs[0], "after_to");
`else
    mb = mvalid_cnt;
    check("mvalid_idle", 64'(mvalid_cnt - mb), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ap_seq.md
AP_SEQ -- requirements
Module: ap_seq

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, default 8, operand/result word width; CELL_QUANT, default 512, cells per column; ADDR_W, default clog2(CELL_QUANT), AP address width; READ_LAT, default 1, cycles from ap_read_en to valid ap_data_out (1..3); TIMEOUT_CYCLES, default 65535, compute watchdog limit.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset.
REQ-003 Clock port: CLK100MHZ, input, 1 bit, sole clock.
REQ-004 Reset port: rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 Control ports: start (in, 1), one-cycle job request; cmd_in (in, 3), AP opcode; bank_in (in, 1), internal column; busy (out, 1), job active; done (out, 1), one-cycle end pulse; error (out, 1), sticky timeout flag.
REQ-006 Operand stream ports: s_valid (in, 1), s_ready (out, 1), s_data (in, WORD_SIZE); 2*CELL_QUANT beats per job, column A first, then column B.
REQ-007 Result stream ports: m_valid (out, 1), m_ready (in, 1), m_data (out, WORD_SIZE), m_last (out, 1); CELL_QUANT beats per job.
REQ-008 AP-side ports: ap_addr (out, ADDR_W), ap_data (out, WORD_SIZE), ap_write_en, ap_read_en, ap_mode, ap_rst, ap_sel_internal_col (out, 1 each), ap_sel_col (out, 2), ap_cmd (out, 3), ap_data_out (in, WORD_SIZE), ap_state_irq (in, 1).

Function
REQ-009 The FSM SHALL have states IDLE, CLEAR, LOAD_A, LOAD_B, COMPUTE, READ, FINISH.
REQ-010 IDLE: start=1 latches cmd_in and bank_in, goes to CLEAR, and sets busy=1 the next cycle; start is ignored whenever busy=1.
REQ-011 CLEAR: ap_rst=1 for exactly one cycle with ap_sel_internal_col=latched bank, then LOAD_A.
REQ-012 LOAD_A/LOAD_B: s_ready=1; each beat with s_valid&s_ready drives ap_write_en=1, ap_data=s_data, ap_addr=cell index, ap_sel_col=0 (A) or 1 (B) in the following cycle; ap_write_en=0 on cycles with no beat.
REQ-013 The cell index SHALL count 0..CELL_QUANT-1 and wrap to 0; the beat at CELL_QUANT-1 moves LOAD_A to LOAD_B and LOAD_B to COMPUTE.
REQ-014 COMPUTE: ap_mode=1 and ap_cmd=latched cmd until ap_state_irq is sampled high; ap_mode then drops to 0 in the next cycle and the FSM goes to READ.
REQ-015 READ: the block SHALL issue ap_read_en with ap_sel_col=2 and addresses 0..CELL_QUANT-1, capturing ap_data_out READ_LAT cycles after each read into a 4-entry output FIFO.
REQ-016 A read SHALL be issued only when the number of free FIFO entries exceeds the number of reads in flight, so no result is ever dropped under m_ready backpressure.
REQ-017 m_valid SHALL equal FIFO non-empty; m_last=1 on the beat carrying cell CELL_QUANT-1; the FIFO pops on m_valid&m_ready.
REQ-018 After the last beat is popped, FINISH SHALL pulse done for one cycle, set busy=0, and return to IDLE.
REQ-019 Simultaneous FIFO push and pop SHALL leave the FIFO occupancy unchanged.

Reset
REQ-020 While rst_n=0, every output SHALL be 0, the FSM SHALL be in IDLE, and counters, the FIFO and error SHALL be cleared, taking effect asynchronously including mid-job.
REQ-021 AP strobes (ap_write_en, ap_read_en, ap_mode, ap_rst) SHALL be register outputs, glitch-free across reset deassertion.

Configuration
REQ-022 With macro AP_SEQ_TIMEOUT_EN defined, a counter SHALL start at COMPUTE entry; if it reaches TIMEOUT_CYCLES without ap_state_irq, the block SHALL drop ap_mode, set error=1 (cleared only by reset or the next start), pulse done, skip READ, and return to IDLE.
REQ-023 Without AP_SEQ_TIMEOUT_EN, COMPUTE SHALL wait indefinitely and error SHALL be tied to 0.

Verification (WORD_SIZE=8, CELL_QUANT=4, READ_LAT=1, AP model computes C=A|B and raises irq 10 cycles after ap_mode rises)
REQ-024 A={1,2,4,8}, B={16,32,64,128}, cmd=0, m_ready=1 -> m_data 17,34,68,136 with m_last on 136, one done pulse, error=0.
REQ-025 Same data with m_ready toggling 1,0,0,1,... -> identical ordered output with no drops or duplicates, and FIFO occupancy never above 4.
REQ-026 s_valid low on alternate cycles -> ap_write_en high only on accepted beats, with ap_addr 0,1,2,3 for sel_col 0 then 0,1,2,3 for sel_col 1.
REQ-027 AP_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=32, irq never raised -> error=1 and done pulse 32 cycles after ap_mode rises, and no m_valid.
REQ-028 rst_n pulsed low during LOAD_B -> all outputs go to 0 immediately; the next start runs a full job yielding the results of REQ-024.
REQ-029 start asserted during READ -> ignored; a single done pulse occurs and cmd is unchanged.
